// File: rtl/pipe_stage_buffer_pkg.sv
// Shared definitions for the pipeline stage buffer.
//   OCC_W         : width of the occupancy count
//   occ_e         : occupancy encoding; the FSM state is the entry count
//   NOP_CTRL_FILL : fill bit used to build the default bubble control word
//   payload_w()   : packed width of one entry (control word + data words)
package pipe_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [OCC_W-1:0] {
        OCC_EMPTY = 2'd0,
        OCC_FULL  = 2'd1,
        OCC_SKID  = 2'd2
    } occ_e;

    localparam logic NOP_CTRL_FILL = 1'b0;

    function automatic int payload_w(input int ctrl_w, input int data_w, input int n_data);
        return ctrl_w + (n_data * data_w);
    endfunction

endpackage

// File: rtl/pipe_stage_buffer_if.sv
// Handshake bundle between the upstream producer, the stage buffer and the
// downstream consumer.
//   in_valid/in_ready/in_ctrl/in_data : upstream entry handshake
//   flush                             : kill held entries and this cycle's accept
//   out_valid/out_ready/out_ctrl/out_data : downstream entry handshake
//   occupancy                         : entries currently held (0..2)
// Modports: master = environment side (drives inputs of the stage),
//           slave  = the stage buffer itself.
interface pipe_stage_buffer_if
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 12,
    parameter int DATA_W = 32,
    parameter int N_DATA = 3
);
    logic                       in_valid;
    logic                       in_ready;
    logic [CTRL_W-1:0]          in_ctrl;
    logic [N_DATA*DATA_W-1:0]   in_data;
    logic                       flush;
    logic                       out_valid;
    logic                       out_ready;
    logic [CTRL_W-1:0]          out_ctrl;
    logic [N_DATA*DATA_W-1:0]   out_data;
    logic [OCC_W-1:0]           occupancy;

    modport master (
        output in_valid, in_ctrl, in_data, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, occupancy
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, occupancy
    );

endinterface

// File: rtl/pipe_stage_buffer_slot.sv
// One payload register of the stage buffer (control word + data words).
//   clock  : rising-edge clock
//   clr    : asynchronous active-high reset, clears the payload to zero
//   i_load : capture i_d on the next rising edge
//   i_d    : payload to capture
//   o_q    : held payload
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         clr,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Payload storage: cleared by reset, otherwise loaded on demand.
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// synchronous flush and a bubble (NOP) output mux. Latency is one cycle.
//   clock : rising-edge clock
//   clr   : asynchronous active-high reset
//   bus   : slave side of pipe_stage_buffer_if (in_*, flush, out_*, occupancy)
// Parameters: CTRL_W, DATA_W, N_DATA set the payload shape; NOP_CTRL is the
// control word shown while no entry is held; SKID selects a 2-entry buffer
// with registered in_ready (1) or a single entry with combinational in_ready (0).
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int                CTRL_W   = 12,
    parameter int                DATA_W   = 32,
    parameter int                N_DATA   = 3,
    parameter logic [CTRL_W-1:0] NOP_CTRL = {CTRL_W{NOP_CTRL_FILL}},
    parameter bit                SKID     = 1'b1
) (
    input logic               clock,
    input logic               clr,
    pipe_stage_buffer_if.slave bus
);

    localparam int PW = payload_w(CTRL_W, DATA_W, N_DATA);
    localparam int DW = N_DATA * DATA_W;

    occ_e          r_occ;
    occ_e          w_occ_nxt;
    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_accept;
    logic          w_emit;
    logic          w_load_main;
    logic          w_load_skid;
    logic          w_main_from_skid;
    logic [PW-1:0] w_in_payload;
    logic [PW-1:0] w_main_d;
    logic [PW-1:0] w_main_q;
    logic [PW-1:0] w_skid_q;

    assign w_in_payload = {bus.in_ctrl, bus.in_data};
    assign w_out_valid  = (r_occ != OCC_EMPTY);
    assign w_accept     = bus.in_valid & w_in_ready;
    assign w_emit       = w_out_valid & bus.out_ready;

    generate
        if (SKID) begin : g_skid
            logic r_in_ready;

            // in_ready is registered from the next occupancy so out_ready never
            // reaches in_ready combinationally.
            always_ff @(posedge clock or posedge clr) begin
                if (clr) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_occ_nxt != OCC_SKID);
                end
            end

            assign w_in_ready = r_in_ready;

            pipe_slot #(.W(PW)) u_skid_slot (
                .clock  (clock),
                .clr    (clr),
                .i_load (w_load_skid),
                .i_d    (w_in_payload),
                .o_q    (w_skid_q)
            );
        end else begin : g_noskid
            // Single entry: accept when empty or when the held entry leaves now.
            assign w_in_ready = ~w_out_valid | bus.out_ready;
            assign w_skid_q   = '0;
        end
    endgenerate

    pipe_slot #(.W(PW)) u_main_slot (
        .clock  (clock),
        .clr    (clr),
        .i_load (w_load_main),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    // Occupancy state register.
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            r_occ <= OCC_EMPTY;
        end else begin
            r_occ <= w_occ_nxt;
        end
    end

    // Next occupancy and slot load enables; flush overrides every transition
    // and suppresses loads so the data registers keep their last contents.
    always_comb begin
        w_occ_nxt        = r_occ;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_occ)
            OCC_EMPTY: begin
                if (w_accept) begin
                    w_occ_nxt   = OCC_FULL;
                    w_load_main = 1'b1;
                end else begin
                    w_occ_nxt = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (w_accept && w_emit) begin
                    w_occ_nxt   = OCC_FULL;
                    w_load_main = 1'b1;
                end else if (w_accept) begin
                    w_occ_nxt   = OCC_SKID;
                    w_load_skid = 1'b1;
                end else if (w_emit) begin
                    w_occ_nxt = OCC_EMPTY;
                end else begin
                    w_occ_nxt = OCC_FULL;
                end
            end
            OCC_SKID: begin
                if (w_emit) begin
                    w_occ_nxt        = OCC_FULL;
                    w_load_main      = 1'b1;
                    w_main_from_skid = 1'b1;
                end else begin
                    w_occ_nxt = OCC_SKID;
                end
            end
            default: begin
                w_occ_nxt = OCC_EMPTY;
            end
        endcase
        if (bus.flush) begin
            w_occ_nxt   = OCC_EMPTY;
            w_load_main = 1'b0;
            w_load_skid = 1'b0;
        end else begin
            w_occ_nxt = w_occ_nxt;
        end
    end

    // Main slot source: the skid entry moves forward when it is promoted.
    always_comb begin
        if (w_main_from_skid) begin
            w_main_d = w_skid_q;
        end else begin
            w_main_d = w_in_payload;
        end
    end

    // Outputs decoded from registered state; control is forced to NOP_CTRL
    // while empty so downstream may ignore out_valid.
    always_comb begin
        bus.in_ready  = w_in_ready;
        bus.out_valid = w_out_valid;
        bus.occupancy = r_occ;
        bus.out_data  = w_main_q[DW-1:0];
        if (w_out_valid) begin
            bus.out_ctrl = w_main_q[PW-1 -: CTRL_W];
        end else begin
            bus.out_ctrl = NOP_CTRL;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
module tb_pipe_stage_buffer;

    logic         clock   = 1'b0;
    logic         clr     = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_ready = 1'b0;
    logic         s_flush = 1'b0;
    logic [11:0]  s_ctrl  = 12'd0;
    logic [127:0] s_data  = 128'd0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    // dut 0: SKID=1 default shape; dut 1: SKID=0 with NOP_CTRL=FFF; dut 2: SKID=1, 4x16-bit words
    pipe_stage_buffer_if #(.CTRL_W(12), .DATA_W(32), .N_DATA(3)) bus_a ();
    pipe_stage_buffer_if #(.CTRL_W(12), .DATA_W(32), .N_DATA(3)) bus_b ();
    pipe_stage_buffer_if #(.CTRL_W(12), .DATA_W(16), .N_DATA(4)) bus_c ();

    assign bus_a.in_valid = s_valid;  assign bus_b.in_valid = s_valid;  assign bus_c.in_valid = s_valid;
    assign bus_a.out_ready = s_ready; assign bus_b.out_ready = s_ready; assign bus_c.out_ready = s_ready;
    assign bus_a.flush = s_flush;     assign bus_b.flush = s_flush;     assign bus_c.flush = s_flush;
    assign bus_a.in_ctrl = s_ctrl;    assign bus_b.in_ctrl = s_ctrl;    assign bus_c.in_ctrl = s_ctrl;
    assign bus_a.in_data = s_data[95:0];
    assign bus_b.in_data = s_data[95:0];
    assign bus_c.in_data = s_data[63:0];

    pipe_stage_buffer #(.CTRL_W(12), .DATA_W(32), .N_DATA(3), .SKID(1'b1)) u_dut_a (
        .clock (clock), .clr (clr), .bus (bus_a.slave));
    pipe_stage_buffer #(.CTRL_W(12), .DATA_W(32), .N_DATA(3), .NOP_CTRL(12'hFFF), .SKID(1'b0)) u_dut_b (
        .clock (clock), .clr (clr), .bus (bus_b.slave));
    pipe_stage_buffer #(.CTRL_W(12), .DATA_W(16), .N_DATA(4), .SKID(1'b1)) u_dut_c (
        .clock (clock), .clr (clr), .bus (bus_c.slave));

    logic         o_valid [3];
    logic         o_ready [3];
    logic [11:0]  o_ctrl  [3];
    logic [1:0]   o_occ   [3];
    logic [127:0] o_data  [3];

    assign o_valid[0] = bus_a.out_valid; assign o_valid[1] = bus_b.out_valid; assign o_valid[2] = bus_c.out_valid;
    assign o_ready[0] = bus_a.in_ready;  assign o_ready[1] = bus_b.in_ready;  assign o_ready[2] = bus_c.in_ready;
    assign o_ctrl[0]  = bus_a.out_ctrl;  assign o_ctrl[1]  = bus_b.out_ctrl;  assign o_ctrl[2]  = bus_c.out_ctrl;
    assign o_occ[0]   = bus_a.occupancy; assign o_occ[1]   = bus_b.occupancy; assign o_occ[2]   = bus_c.occupancy;
    assign o_data[0]  = {32'd0, bus_a.out_data};
    assign o_data[1]  = {32'd0, bus_b.out_data};
    assign o_data[2]  = {64'd0, bus_c.out_data};

    // Reference model: a FIFO of at most 2 (SKID=1) or 1 (SKID=0) entries per dut.
    bit           m_skid [3] = '{1'b1, 1'b0, 1'b1};
    logic [11:0]  m_nop  [3] = '{12'h000, 12'hFFF, 12'h000};
    logic [127:0] m_mask [3] = '{{32'd0, {96{1'b1}}}, {32'd0, {96{1'b1}}}, {64'd0, {64{1'b1}}}};
    int           m_cnt  [3];
    logic [11:0]  m_ctrl [3][2];
    logic [127:0] m_dat  [3][2];
    logic [127:0] m_last [3];

    function automatic bit m_in_ready(input int d);
        if (m_skid[d]) return (m_cnt[d] < 2);
        return (m_cnt[d] == 0) || (s_ready == 1'b1);
    endfunction

    function automatic bit e_valid(input int d);
        return (m_cnt[d] > 0);
    endfunction

    function automatic logic [11:0] e_ctrl(input int d);
        return (m_cnt[d] > 0) ? m_ctrl[d][0] : m_nop[d];
    endfunction

    function automatic logic [1:0] e_occ(input int d);
        return 2'(m_cnt[d]);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_cnt[d]  = 0;
            m_last[d] = 128'd0;
        end
    endtask

    // Advance one clock: update the model with the sampled inputs, then settle.
    task automatic tick();
        @(posedge clock);
        for (int d = 0; d < 3; d++) begin
            bit acc;
            bit emt;
            acc = s_valid && m_in_ready(d);
            emt = (m_cnt[d] > 0) && s_ready;
            if (s_flush) begin
                m_cnt[d] = 0;
            end else begin
                if (emt) begin
                    m_ctrl[d][0] = m_ctrl[d][1];
                    m_dat[d][0]  = m_dat[d][1];
                    m_cnt[d]     = m_cnt[d] - 1;
                end
                if (acc) begin
                    m_ctrl[d][m_cnt[d]] = s_ctrl;
                    m_dat[d][m_cnt[d]]  = s_data & m_mask[d];
                    m_cnt[d]            = m_cnt[d] + 1;
                end
            end
            if (m_cnt[d] > 0) m_last[d] = m_dat[d][0];
        end
        #1;
    endtask

    task automatic test_reset();
        s_valid = 1'b0; s_ready = 1'b0; s_flush = 1'b0; s_ctrl = 12'd0; s_data = 128'd0;
        clr = 1'b1;
        @(negedge clock);
        #2;
        clr = 1'b0;
        model_reset();
        tick();
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (o_valid[d] !== 1'b0 || o_ctrl[d] !== m_nop[d] || o_data[d] !== 128'd0 ||
                o_occ[d] !== 2'd0 || o_ready[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset dut%0d: got v=%0b ctrl=%h data=%h occ=%0d rdy=%0b, expected v=0 ctrl=%h data=0 occ=0 rdy=1",
                         d, o_valid[d], o_ctrl[d], o_data[d], o_occ[d], o_ready[d], m_nop[d]);
            end
        end
    endtask

    task automatic test_stream();
        for (int k = 1; k <= 8; k++) begin
            s_valid = 1'b1; s_ready = 1'b1; s_flush = 1'b0; s_ctrl = 12'(k);
            s_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
            n_tests++;
            if (o_valid[0] !== 1'b1 || o_ctrl[0] !== 12'(k) || o_occ[0] !== 2'd1) begin
                n_fail++;
                $display("FAIL stream step %0d: got v=%0b ctrl=%h occ=%0d, expected v=1 ctrl=%h occ=1",
                         k, o_valid[0], o_ctrl[0], o_occ[0], 12'(k));
            end
            for (int d = 0; d < 3; d++) begin
                n_tests++;
                if ({o_valid[d], o_ctrl[d], o_occ[d], o_ready[d]} !== {e_valid(d), e_ctrl(d), e_occ(d), m_in_ready(d)} ||
                    o_data[d] !== m_last[d]) begin
                    n_fail++;
                    $display("FAIL stream_model dut%0d: got v=%0b ctrl=%h occ=%0d rdy=%0b data=%h, expected v=%0b ctrl=%h occ=%0d rdy=%0b data=%h",
                             d, o_valid[d], o_ctrl[d], o_occ[d], o_ready[d], o_data[d],
                             e_valid(d), e_ctrl(d), e_occ(d), m_in_ready(d), m_last[d]);
                end
            end
        end
        s_valid = 1'b0;
        tick();
    endtask

    // Directed step table: inputs, then expected dut0 valid/ctrl/occupancy/in_ready.
    task automatic run_table(input string name, input int n, input bit tv[], input bit tr[], input bit tf[],
                             input int tc[], input bit ev[], input int ec[], input int eo[], input bit er[]);
        for (int i = 0; i < n; i++) begin
            s_valid = tv[i]; s_ready = tr[i]; s_flush = tf[i]; s_ctrl = 12'(tc[i]);
            s_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
            n_tests++;
            if (o_valid[0] !== ev[i] || o_ctrl[0] !== 12'(ec[i]) || o_occ[0] !== 2'(eo[i]) || o_ready[0] !== er[i]) begin
                n_fail++;
                $display("FAIL %s step %0d: got v=%0b ctrl=%h occ=%0d rdy=%0b, expected v=%0b ctrl=%h occ=%0d rdy=%0b",
                         name, i, o_valid[0], o_ctrl[0], o_occ[0], o_ready[0], ev[i], 12'(ec[i]), 2'(eo[i]), er[i]);
            end
            for (int d = 0; d < 3; d++) begin
                n_tests++;
                if ({o_valid[d], o_ctrl[d], o_occ[d], o_ready[d]} !== {e_valid(d), e_ctrl(d), e_occ(d), m_in_ready(d)} ||
                    o_data[d] !== m_last[d]) begin
                    n_fail++;
                    $display("FAIL %s_model step %0d dut%0d: got v=%0b ctrl=%h occ=%0d rdy=%0b, expected v=%0b ctrl=%h occ=%0d rdy=%0b",
                             name, i, d, o_valid[d], o_ctrl[d], o_occ[d], o_ready[d],
                             e_valid(d), e_ctrl(d), e_occ(d), m_in_ready(d));
                end
            end
        end
        s_flush = 1'b0;
    endtask

    task automatic test_backpressure();
        // hold 5, park 6 in skid, 7 refused, then drain 5 then 6
        run_table("backpressure", 5,
                  '{1, 1, 1, 0, 0}, '{0, 0, 0, 1, 1}, '{0, 0, 0, 0, 0}, '{5, 6, 7, 0, 0},
                  '{1, 1, 1, 1, 0}, '{5, 5, 5, 6, 0}, '{1, 2, 2, 1, 0}, '{1, 0, 0, 1, 1});
    endtask

    task automatic test_flush();
        // fill to skid, flush with 9 offered, flush-with-accept from empty, flush on empty, recover
        run_table("flush", 8,
                  '{1, 1, 1, 0, 1, 0, 1, 0}, '{0, 0, 0, 1, 1, 1, 1, 1}, '{0, 0, 1, 0, 1, 1, 0, 0},
                  '{7, 8, 9, 0, 3, 0, 4, 0},
                  '{1, 1, 0, 0, 0, 0, 1, 0}, '{7, 7, 0, 0, 0, 0, 4, 0}, '{1, 2, 0, 0, 0, 0, 1, 0},
                  '{1, 0, 1, 1, 1, 1, 1, 1});
    endtask

    task automatic test_noskid();
        s_valid = 1'b1; s_ready = 1'b0; s_flush = 1'b0; s_ctrl = 12'd4;
        s_data = {$urandom, $urandom, $urandom, $urandom};
        tick();
        s_ctrl = 12'd11;
        #1;
        n_tests++;
        if (o_ready[1] !== 1'b0 || o_occ[1] !== 2'd1 || o_ctrl[1] !== 12'd4) begin
            n_fail++;
            $display("FAIL noskid_full: got rdy=%0b occ=%0d ctrl=%h, expected rdy=0 occ=1 ctrl=004",
                     o_ready[1], o_occ[1], o_ctrl[1]);
        end
        s_ready = 1'b1; s_ctrl = 12'd10;
        s_data = {$urandom, $urandom, $urandom, $urandom};
        #1;
        n_tests++;
        if (o_ready[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL noskid_ready_comb: got rdy=%0b, expected rdy=1", o_ready[1]);
        end
        tick();
        n_tests++;
        if (o_valid[1] !== 1'b1 || o_ctrl[1] !== 12'd10 || o_occ[1] !== 2'd1 || o_data[1] !== m_last[1]) begin
            n_fail++;
            $display("FAIL noskid_swap: got v=%0b ctrl=%h occ=%0d data=%h, expected v=1 ctrl=00a occ=1 data=%h",
                     o_valid[1], o_ctrl[1], o_occ[1], o_data[1], m_last[1]);
        end
        s_valid = 1'b0;
        tick();
        n_tests++;
        if (o_valid[1] !== 1'b0 || o_ctrl[1] !== 12'hFFF || o_occ[1] !== 2'd0) begin
            n_fail++;
            $display("FAIL noskid_drain: got v=%0b ctrl=%h occ=%0d, expected v=0 ctrl=fff occ=0",
                     o_valid[1], o_ctrl[1], o_occ[1]);
        end
    endtask

    task automatic test_wide();
        logic [15:0] lane;
        s_data = {$urandom, $urandom, 32'd0, 32'd0};
        for (int k = 0; k < 4; k++) s_data[k*16 +: 16] = 16'hA000 + 16'(k);
        s_valid = 1'b1; s_ready = 1'b1; s_flush = 1'b0; s_ctrl = 12'h0AB;
        tick();
        for (int k = 0; k < 4; k++) begin
            lane = o_data[2][k*16 +: 16];
            n_tests++;
            if (lane !== 16'hA000 + 16'(k)) begin
                n_fail++;
                $display("FAIL wide_lane%0d: got %h, expected %h", k, lane, 16'hA000 + 16'(k));
            end
        end
        s_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_clr();
        s_valid = 1'b1; s_ready = 1'b0; s_flush = 1'b0; s_ctrl = 12'd1;
        tick();
        s_ctrl = 12'd2;
        tick();
        n_tests++;
        if (o_occ[0] !== 2'd2) begin
            n_fail++;
            $display("FAIL async_setup: got occ=%0d, expected occ=2", o_occ[0]);
        end
        #2;
        clr = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (o_valid[d] !== 1'b0 || o_occ[d] !== 2'd0 || o_ctrl[d] !== m_nop[d]) begin
                n_fail++;
                $display("FAIL async_clr dut%0d: got v=%0b occ=%0d ctrl=%h, expected v=0 occ=0 ctrl=%h",
                         d, o_valid[d], o_occ[d], o_ctrl[d], m_nop[d]);
            end
        end
        #1;
        clr = 1'b0;
        s_valid = 1'b0;
        model_reset();
        tick();
        n_tests++;
        if (o_ready[0] !== 1'b1 || o_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL async_release: got rdy=%0b v=%0b, expected rdy=1 v=0", o_ready[0], o_valid[0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_ready = ($urandom_range(0, 2) != 0);
            s_flush = ($urandom_range(0, 15) == 0);
            s_ctrl  = 12'($urandom);
            s_data  = {$urandom, $urandom, $urandom, $urandom};
            tick();
            for (int d = 0; d < 3; d++) begin
                n_tests++;
                if ({o_valid[d], o_ctrl[d], o_occ[d], o_ready[d]} !== {e_valid(d), e_ctrl(d), e_occ(d), m_in_ready(d)} ||
                    o_data[d] !== m_last[d]) begin
                    n_fail++;
                    $display("FAIL random cyc %0d dut%0d: got v=%0b ctrl=%h occ=%0d rdy=%0b data=%h, expected v=%0b ctrl=%h occ=%0d rdy=%0b data=%h",
                             i, d, o_valid[d], o_ctrl[d], o_occ[d], o_ready[d], o_data[d],
                             e_valid(d), e_ctrl(d), e_occ(d), m_in_ready(d), m_last[d]);
                end
            end
        end
        s_valid = 1'b0; s_flush = 1'b0; s_ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_noskid();
        test_wide();
        test_async_clr();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
